alu_ex_stage: RTL and testbench
===============================

# alu_ex_stage

Execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder, together with two operands, and delivers a registered result and zero flag to the EX/MEM boundary. Single-cycle ops complete in one clock. A 32-step iterative multiply runs as a multi-cycle operation. Valid/ready handshakes on both sides let the pipeline stall cleanly around multi-cycle work.

## Interface
- WIDTH, 32, operand/result width; multiply takes WIDTH iteration cycles
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- in_valid  input  1  operands and alu_ctr are presented
- in_ready  output  1  stage can accept this cycle (combinational)
- alu_ctr  input  4  operation code
- src_a  input  WIDTH  operand A
- src_b  input  WIDTH  operand B
- out_valid  output  1  result/zero are valid
- out_ready  input  1  downstream takes result this cycle
- result  output  WIDTH  registered result
- zero  output  1  registered, 1 when result == 0

## Operation
- Codes:
  - 0010 add
  - 0110 sub (A−B)
  - 0000 AND
  - 0001 OR
  - 0111 signed set-less-than (result 1 or 0)
  - 1100 NOR
  - 1000 multiply, low WIDTH bits of unsigned A×B
- Any other code: result 0, zero 1, completes as a single-cycle op.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Accept = in_valid & in_ready at a rising edge.
- in_ready = (state == IDLE) & (!out_valid | out_ready).
- State machine:
  - IDLE: on accept of a single-cycle op, load result/zero and set out_valid; stay in IDLE. On accept of 1000, capture multiplicand = A, multiplier = B, clear accumulator, count = WIDTH, go to MUL.
  - MUL: each cycle, if multiplier LSB is 1, add multiplicand to accumulator; shift multiplicand left 1 and multiplier right 1; decrement count. At the edge where count goes 1→0, load the final accumulator into result, set zero and out_valid, and return to IDLE.
- Output register: out_valid stays 1 and result/zero stay stable until out_ready is sampled 1.
  - Drain and new load on the same edge: the new value replaces the old, and out_valid stays 1.
  - Drain with no new load: out_valid goes 0; result keeps its old value.
- The output register is always empty during MUL. Accept requires the output to be empty or draining, so multiply completion never overwrites an unconsumed result.
- Inputs presented while in_ready = 0 are ignored; the upstream stage holds them.

## Timing
- Reset (asynchronous, immediate): state IDLE, out_valid 0, result 0, zero 0, multiply registers and count 0. in_ready reads 1 while reset is deasserted and state is IDLE.
- Reset during MUL aborts the multiply; no result is ever produced for it.
- Single-cycle op accepted at edge N: out_valid = 1 after edge N. Back-to-back accepts are possible every cycle while out_ready = 1.
- Multiply accepted at edge N: in_ready = 0 after edges N .. N+WIDTH−1. out_valid = 1 after edge N+WIDTH. in_ready returns to 1 after edge N+WIDTH provided out_ready = 1.
- Zero is computed from the value being loaded into result, in the same edge.

## Test plan
- Add: A = 5, B = 7, code 0010 → result 12, zero 0, one cycle after accept. Sub: A = 9, B = 9, code 0110 → result 0, zero 1.
- Signed compare: A = 0xFFFFFFFF, B = 1, code 0111 → result 1. Swap the operands → result 0. NOR of 0 and 0 → 0xFFFFFFFF.
- Backpressure: hold out_ready = 0 after an add completes.
  - in_ready drops to 0 and result stays stable for 5 cycles.
  - Assert out_ready: the next queued op is accepted on that same edge.
- Multiply: A = 0x0001_0003, B = 7, code 1000 → result 0x0007_0015, out_valid exactly 32 edges after accept.
  - in_valid held high with an add during the multiply is not accepted until in_ready returns.
  - A = 0xFFFFFFFF, B = 2 → 0xFFFFFFFE.
- Reset mid-multiply: assert reset at iteration 10 → out_valid 0, result 0, state IDLE immediately. A following add completes normally.
- Undefined code 1111 → result 0, zero 1, out_valid after one cycle.

Source files
------------

// File: rtl/alu_ex_stage.sv
// EX-stage ALU: single-cycle ops land in the output register one edge after accept; multiply takes WIDTH iterations.
// Valid/ready on both sides; in_ready drops while multiplying or while an unconsumed result is held.
module alu_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctr,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;

  logic             accept;
  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] acc_next;

  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    op_res = '0;
    case (alu_ctr)
      OP_ADD:  op_res = src_a + src_b;
      OP_SUB:  op_res = src_a - src_b;
      OP_AND:  op_res = src_a & src_b;
      OP_OR:   op_res = src_a | src_b;
      OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_NOR:  op_res = ~(src_a | src_b);
      default: op_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (out_valid && out_ready)
            out_valid <= 1'b0;
          if (accept) begin
            if (alu_ctr == OP_MUL) begin
              mcand  <= src_a;
              mplier <= src_b;
              acc    <= '0;
              count  <= CW'(WIDTH);
              state  <= MUL;
            end else begin
              result    <= op_res;
              zero      <= (op_res == '0);
              out_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          // Output register is guaranteed empty here, so completion may load it unconditionally.
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            result    <= acc_next;
            zero      <= (acc_next == '0);
            out_valid <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: vector table, hand-written handshake/multiply/reset sequences, then random traffic vs a model.
module tb_alu_ex_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctr;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;

  int n_cmp = 0;
  int n_bad = 0;

  alu_ex_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .alu_ctr(alu_ctr),
    .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   code;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Reference: the operation table evaluated with plain arithmetic.
  function automatic logic [W-1:0] ref_alu(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
    case (c)
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd7:    return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd12:   return ~(a | b);
      4'd8:    return a * b;
      default: return '0;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int rdy_seen;
    int ov_seen;
    int busy;
    logic         mov, mz, exp_rdy;
    logic [W-1:0] mres, pend;
    logic [3:0]   cl[9];

    tbl[0] = '{4'b0010, 32'd5,        32'd7,        32'd12,       1'b0};
    tbl[1] = '{4'b0110, 32'd9,        32'd9,        32'd0,        1'b1};
    tbl[2] = '{4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0};
    tbl[3] = '{4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1};
    tbl[4] = '{4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0};
    tbl[5] = '{4'b0000, 32'hFFFF00F0, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0};
    tbl[6] = '{4'b0001, 32'h12000034, 32'h00560000, 32'h12560034, 1'b0};
    tbl[7] = '{4'b1111, 32'd123,      32'd456,      32'd0,        1'b1};
    tbl[8] = '{4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1};
    tbl[9] = '{4'b0110, 32'd3,        32'd5,        32'hFFFFFFFE, 1'b0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctr = 4'd0; src_a = '0; src_b = '0;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_zero", zero, 0);
    #20 reset = 1'b0;
    #1 chk("reset_in_ready", in_ready, 1);
    step;

    // Vector table, back to back with out_ready held high.
    for (int i = 0; i < 10; i++) begin
      alu_ctr = tbl[i].code; src_a = tbl[i].a; src_b = tbl[i].b; in_valid = 1'b1;
      step;
      chk($sformatf("vec%0d_out_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_result", i), result, tbl[i].res);
      chk($sformatf("vec%0d_zero", i), zero, tbl[i].z);
    end
    in_valid = 1'b0;
    step;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_result_kept", result, 32'hFFFFFFFE);

    // Backpressure: hold a result, queue the next op.
    out_ready = 1'b0;
    alu_ctr = 4'b0010; src_a = 32'd5; src_b = 32'd7; in_valid = 1'b1;
    step;
    chk("bp_first_result", result, 12);
    src_a = 32'd1; src_b = 32'd1;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      step;
      chk($sformatf("bp_result_%0d", k), result, 12);
      chk($sformatf("bp_out_valid_%0d", k), out_valid, 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 1);
    step;
    chk("bp_next_result", result, 2);
    chk("bp_next_out_valid", out_valid, 1);
    in_valid = 1'b0;
    step;
    chk("bp_drained", out_valid, 0);
    chk("bp_result_kept", result, 2);

    // Multiply latency, with an add held on the input throughout.
    alu_ctr = 4'b1000; src_a = 32'h0001_0003; src_b = 32'd7; in_valid = 1'b1;
    step;
    alu_ctr = 4'b0010; src_a = 32'd3; src_b = 32'd4;
    chk("mul_in_ready_after_accept", in_ready, 0);
    lat = 0; rdy_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (in_ready) rdy_seen++;
    end
    chk("mul_latency", lat, 32);
    chk("mul_ready_while_busy", rdy_seen, 0);
    chk("mul_result", result, 32'h0007_0015);
    chk("mul_zero", zero, 0);
    chk("mul_in_ready_done", in_ready, 1);
    step;
    chk("after_mul_add_result", result, 7);
    chk("after_mul_add_valid", out_valid, 1);
    in_valid = 1'b0;
    step;

    alu_ctr = 4'b1000; src_a = 32'hFFFFFFFF; src_b = 32'd2; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk("mul2_latency", lat, 32);
    chk("mul2_result", result, 32'hFFFFFFFE);
    step;

    // Reset during a multiply aborts it.
    alu_ctr = 4'b1000; src_a = 32'd5; src_b = 32'd5; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (10) step;
    reset = 1'b1;
    #1;
    chk("rst_mul_out_valid", out_valid, 0);
    chk("rst_mul_result", result, 0);
    chk("rst_mul_zero", zero, 0);
    #2 reset = 1'b0;
    #1 chk("rst_mul_in_ready", in_ready, 1);
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      step;
      if (out_valid) ov_seen++;
    end
    chk("rst_mul_no_result", ov_seen, 0);
    alu_ctr = 4'b0010; src_a = 32'd2; src_b = 32'd3; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    chk("rst_add_valid", out_valid, 1);
    chk("rst_add_result", result, 5);

    // Random traffic against a transaction-level model.
    reset = 1'b1;
    #1 reset = 1'b0;
    mov = 1'b0; mres = '0; mz = 1'b0; busy = 0; pend = '0;
    cl = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12, 4'd8, 4'd15, 4'd5};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      alu_ctr   = cl[$urandom_range(0, 8)];
      src_a     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      src_b     = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 7)) : W'($urandom);
      #1;
      exp_rdy = (busy == 0) && (!mov || out_ready);
      chk("rnd_in_ready", in_ready, exp_rdy);
      if (mov && out_ready) mov = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mov = 1'b1; mres = pend; mz = (pend == '0);
        end
      end else if (in_valid && exp_rdy) begin
        if (alu_ctr == 4'b1000) begin
          busy = W;
          pend = ref_alu(alu_ctr, src_a, src_b);
        end else begin
          mov = 1'b1;
          mres = ref_alu(alu_ctr, src_a, src_b);
          mz = (mres == '0);
        end
      end
      step;
      chk("rnd_out_valid", out_valid, mov);
      chk("rnd_result", result, mres);
      chk("rnd_zero", zero, mz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
